rr_priority_arbiter: RTL
========================

// Module: rr_priority_arbiter
// PURPOSE
//  - Parametrised, clocked successor to the combinational rotating priority encoder.
//  - Arbitrates N request lines and registers a one-hot grant, its index and a valid flag.
//  - Two search modes: fixed-rotation (software base index) or round-robin (internal pointer).
//  - Adds grant locking with a bounded tenure. Sits in front of shared resources (bus, shifter, memory port).
// PARAMETERS
//  N         8            number of requesters, >=2
//  IDXW      $clog2(N)    index width
//  LOCK_MAX  16           max consecutive grant cycles while others wait; 0 = unlimited
// PORTS
//  clk          in   1     rising-edge clock
//  rst          in   1     asynchronous, active-high reset
//  req          in   N     request vector, bit i = requester i
//  mode         in   1     0 = search starts at prio_base; 1 = search starts at internal pointer
//  prio_base    in   IDXW  highest-priority index in mode 0 (values >= N treated modulo N)
//  grant        out  N     registered one-hot grant (all zero when idle)
//  grant_idx    out  IDXW  registered index of grant owner (0 when idle)
//  grant_valid  out  1     registered; 1 while a requester holds the grant
//  grant_new    out  1     one-cycle pulse in the cycle a new owner first appears on grant
// BEHAVIOUR
//  - Reset (async): grant=0, grant_idx=0, grant_valid=0, grant_new=0, ptr=0, tenure=0, state=IDLE.
//  - Search:
//    - start = mode ? ptr : (prio_base mod N).
//    - winner = first set bit of the candidate vector at index (start+k) mod N, k=0..N-1.
//    - Wrap-around is required: start=6, N=8, req bits 1 and 7 set -> winner 7.
//  - FSM states: IDLE, BUSY.
//    - IDLE, req==0: stay IDLE; outputs zero.
//    - IDLE, req!=0: register winner over req. Next cycle grant valid, grant_new=1, state BUSY.
//      Latency is 1 clock from req sampled to grant visible.
//    - BUSY, req[owner]=1, no forced release: hold owner unchanged. tenure++ (saturating). grant_new=0.
//    - BUSY, req[owner]=0:
//      - If other requests are pending, switch directly to the winner over req with the owner masked.
//        grant_new=1; no idle bubble.
//      - Otherwise go IDLE with outputs zero next cycle.
//    - Forced release (LOCK_MAX!=0): tenure==LOCK_MAX-1 and some other req pending.
//      - Switch to the winner over req with the owner masked, even though req[owner]=1.
//      - If no other req is pending, the owner keeps the grant and tenure saturates.
//  - tenure resets to 0 on every owner change and on entry to IDLE.
//  - Pointer: on every new-owner grant (both modes), ptr <= (winner+1) mod N. Only mode 1 reads ptr.
//  - mode and prio_base are sampled only when a new winner is chosen. Changes never preempt the current owner.
//  - Simultaneous owner drop and forced release: treated as owner drop (same result).
//  - Reset mid-tenure: outputs clear immediately (async); arbitration restarts from ptr=0.
//  - Invariants: grant is always one-hot or zero; grant_valid == |grant; grant_idx matches grant.
// TESTING
//  1 Reset: assert rst mid-BUSY (owner 3) -> same cycle grant=0, grant_valid=0; after release, req=8'h81, mode=1 -> grant_idx=0.
//  2 Fixed mode: mode=0, prio_base=6, req=8'h82 -> one clock later grant=8'h80, grant_idx=7, grant_new=1.
//  3 Round robin: mode=1, req=8'hFF, each owner drops req one cycle after grant_new -> owner sequence 0,1,2,...,7,0 with no idle cycles.
//  4 Lock timeout: LOCK_MAX=4, req[2] held high from grant onward, req[5] raised -> owner 2 for exactly 4 cycles, then grant_idx=5 with grant_new=1.
//  5 Lone holder: LOCK_MAX=4, only req[1] high for 20 cycles -> grant_idx=1 throughout; grant_new pulses once.
//  6 Drop to idle: single owner 4 drops req, req=0 -> next cycle grant=0, grant_valid=0; later req=8'h10 -> grant_new=1 again.

Source files
------------

// File: rtl/rr_priority_arbiter.sv
// Registered rotating-priority / round-robin arbiter with one-hot grant and
// bounded lock tenure. The search starts at prio_base (mode 0) or at an internal pointer (mode 1).
module rr_priority_arbiter #(
  parameter int N        = 8,
  parameter int IDXW     = $clog2(N),
  parameter int LOCK_MAX = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic            mode,
  input  logic [IDXW-1:0] prio_base,
  output logic [N-1:0]    grant,
  output logic [IDXW-1:0] grant_idx,
  output logic            grant_valid,
  output logic            grant_new
);

  // With LOCK_MAX == 0 the tenure counter only saturates at its all-ones value and never forces.
  localparam int TW      = (LOCK_MAX > 2) ? $clog2(LOCK_MAX) : 1;
  localparam int CAP_INT = (LOCK_MAX == 0) ? ((1 << TW) - 1) : (LOCK_MAX - 1);
  localparam logic [TW-1:0] TEN_CAP = TW'(CAP_INT);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state_reg, state_next;
  logic [N-1:0]    grant_reg, grant_next;
  logic [IDXW-1:0] idx_reg, idx_next;
  logic            valid_reg, valid_next;
  logic            new_reg, new_next;
  logic [IDXW-1:0] ptr_reg, ptr_next;
  logic [TW-1:0]   tenure_reg, tenure_next;

  logic [IDXW:0]   base_ext;
  logic [IDXW-1:0] start_idx;
  logic [N-1:0]    others;
  logic [N-1:0]    cand;
  logic [IDXW-1:0] win_idx;
  logic [IDXW-1:0] win_inc;
  logic [N-1:0]    win_onehot;
  logic            owner_held;
  logic            force_release;

  // Circular search: first set bit at (start + k) mod N.
  function automatic logic [IDXW-1:0] find_first(input logic [N-1:0] vec,
                                                  input logic [IDXW-1:0] start);
    logic [IDXW-1:0] win;
    logic            found;
    logic [IDXW:0]   pos;
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      pos = {1'b0, start} + (IDXW+1)'(k);
      if (pos >= (IDXW+1)'(N)) pos = pos - (IDXW+1)'(N);
      if (!found && vec[pos[IDXW-1:0]]) begin
        win   = pos[IDXW-1:0];
        found = 1'b1;
      end
    end
    return win;
  endfunction

  assign base_ext  = {1'b0, prio_base};
  assign start_idx = mode ? ptr_reg :
                     (base_ext >= (IDXW+1)'(N)) ? IDXW'(base_ext - (IDXW+1)'(N)) : prio_base;
  assign others    = req & ~grant_reg;
  assign cand      = (state_reg == IDLE) ? req : others;
  assign win_idx   = find_first(cand, start_idx);
  assign win_inc   = (win_idx == IDXW'(N - 1)) ? '0 : win_idx + IDXW'(1);

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_onehot
      assign win_onehot[gi] = (win_idx == IDXW'(gi));
    end
  endgenerate

  assign owner_held    = |(req & grant_reg);
  assign force_release = (LOCK_MAX != 0) && (tenure_reg == TEN_CAP) && (|others);

  always_comb begin
    state_next  = state_reg;
    grant_next  = grant_reg;
    idx_next    = idx_reg;
    valid_next  = valid_reg;
    new_next    = 1'b0;
    ptr_next    = ptr_reg;
    tenure_next = tenure_reg;

    if ((state_reg == IDLE && |req) ||
        (state_reg == BUSY && (!owner_held || force_release) && |others)) begin
      state_next  = BUSY;
      grant_next  = win_onehot;
      idx_next    = win_idx;
      valid_next  = 1'b1;
      new_next    = 1'b1;
      ptr_next    = win_inc;
      tenure_next = '0;
    end else if (state_reg == BUSY && owner_held) begin
      tenure_next = (tenure_reg == TEN_CAP) ? TEN_CAP : tenure_reg + TW'(1);
    end else begin
      state_next  = IDLE;
      grant_next  = '0;
      idx_next    = '0;
      valid_next  = 1'b0;
      tenure_next = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      grant_reg  <= '0;
      idx_reg    <= '0;
      valid_reg  <= 1'b0;
      new_reg    <= 1'b0;
      ptr_reg    <= '0;
      tenure_reg <= '0;
    end else begin
      state_reg  <= state_next;
      grant_reg  <= grant_next;
      idx_reg    <= idx_next;
      valid_reg  <= valid_next;
      new_reg    <= new_next;
      ptr_reg    <= ptr_next;
      tenure_reg <= tenure_next;
    end
  end

  assign grant       = grant_reg;
  assign grant_idx   = idx_reg;
  assign grant_valid = valid_reg;
  assign grant_new   = new_reg;

endmodule
